// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller.
//   REG_W         : architectural register index width
//   reg_idx_t     : register index type
//   fwd_sel_e     : operand source select (RF / EX / MEM / WB result)
//   mem_state_e   : data-memory wait FSM states
package pipe_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    MIDLE = 1'b0,
    MWAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one ID-stage source register.
// Purely combinational; the youngest matching producer wins.
// Ports:
//   i_rs, i_use                      : source index and "instruction reads it"
//   i_v_ex/i_ex_rd/i_ex_regwrite/i_ex_is_load : EX producer
//   i_v_mem/i_mem_rd/i_mem_regwrite  : MEM producer
//   i_v_wb/i_wb_rd/i_wb_regwrite     : WB producer
//   o_sel                            : FWD_RF / FWD_EX / FWD_MEM / FWD_WB
module fwd_sel
  import pipe_pkg::*;
(
  input  logic     [REG_W-1:0] i_rs,
  input  logic                 i_use,
  input  logic                 i_v_ex,
  input  logic     [REG_W-1:0] i_ex_rd,
  input  logic                 i_ex_regwrite,
  input  logic                 i_ex_is_load,
  input  logic                 i_v_mem,
  input  logic     [REG_W-1:0] i_mem_rd,
  input  logic                 i_mem_regwrite,
  input  logic                 i_v_wb,
  input  logic     [REG_W-1:0] i_wb_rd,
  input  logic                 i_wb_regwrite,
  output logic     [1:0]       o_sel
);

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  // A load in EX has no data yet, so it is never an EX-stage source;
  // the load-use stall covers that case instead.
  assign w_hit_ex  = i_v_ex & i_ex_regwrite & ~i_ex_is_load &
                     (i_ex_rd != '0) & (i_rs == i_ex_rd);
  assign w_hit_mem = i_v_mem & i_mem_regwrite &
                     (i_mem_rd != '0) & (i_rs == i_mem_rd);
  assign w_hit_wb  = i_v_wb & i_wb_regwrite &
                     (i_wb_rd != '0) & (i_rs == i_wb_rd);

  always_comb begin
    o_sel = FWD_RF;
    if (i_use) begin
      if (w_hit_ex)       o_sel = FWD_EX;
      else if (w_hit_mem) o_sel = FWD_MEM;
      else if (w_hit_wb)  o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the IF/ID/EX/MEM/WB pipeline.
// Tracks a valid bit per stage, stalls on load-use, flushes on EX redirects,
// freezes the whole pipe while data memory is busy (with a bounded wait),
// and produces the ID-stage forwarding selects.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : ID source registers and their use flags
//   ex_*, mem_*, wb_*     : producer info per stage, memory handshake
//   pc_en .. mem_wb_en    : pipeline register enables / bubble loads
//   fwd_a, fwd_b          : operand selects (00 RF, 01 EX, 10 MEM, 11 WB)
//   mem_err               : sticky memory-timeout flag
//   stage_valid           : {v_wb, v_mem, v_ex, v_id}
//   dbg_mem_state         : current memory-wait FSM state
//   stall_cnt/freeze_cnt/flush_cnt : saturating event counters, present
//                           only when PIPE_PERF_CNT_EN is defined
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [3:0]       stage_valid,
  output logic             dbg_mem_state
);

  localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

  // Stage valids
  logic r_v_id, r_v_ex, r_v_mem, r_v_wb;
  logic w_v_id_nxt, w_v_ex_nxt, w_v_mem_nxt, w_v_wb_nxt;

  // Memory wait FSM
  mem_state_e r_state, w_state_nxt;
  logic [7:0] r_mem_cnt, w_mem_cnt_nxt;
  logic       r_mem_err, w_err_set;

  // Hazard terms
  logic w_freeze;
  logic w_timeout;
  logic w_hold;
  logic w_redirect;
  logic w_loaduse;

  assign w_freeze   = r_v_mem & mem_req & ~mem_ready;
  // On the timeout cycle the access is still outstanding, but the pipe is
  // released anyway so a dead memory cannot lock the core forever.
  assign w_timeout  = (r_state == MWAIT) & w_freeze & (r_mem_cnt == LP_TIMEOUT);
  assign w_hold     = w_freeze & ~w_timeout;
  assign w_redirect = r_v_ex & ex_redirect;
  assign w_loaduse  = r_v_id & r_v_ex & ex_is_load & ex_regwrite & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

  // ---------------------------------------------------------------------------
  // Memory wait FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MIDLE;
      r_mem_cnt <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_cnt <= w_mem_cnt_nxt;
      if (w_err_set) r_mem_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_cnt_nxt = r_mem_cnt;
    w_err_set     = 1'b0;
    case (r_state)
      MIDLE: begin
        if (w_freeze) begin
          w_state_nxt   = MWAIT;
          w_mem_cnt_nxt = 8'd1;
        end
      end
      MWAIT: begin
        // Leaving covers both mem_ready and the request going away.
        if (!w_freeze) begin
          w_state_nxt = MIDLE;
        end else if (r_mem_cnt == LP_TIMEOUT) begin
          w_state_nxt = MIDLE;
          w_err_set   = 1'b1;
        end else begin
          w_mem_cnt_nxt = r_mem_cnt + 8'd1;
        end
      end
      default: w_state_nxt = MIDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline register control: freeze > redirect > load-use > advance
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if (w_hold) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (w_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_loaduse) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    w_v_id_nxt  = r_v_id;
    w_v_ex_nxt  = r_v_ex;
    w_v_mem_nxt = r_v_mem;
    w_v_wb_nxt  = r_v_wb;
    if (!w_hold) begin
      w_v_wb_nxt  = r_v_mem;
      w_v_mem_nxt = r_v_ex;
      if (w_redirect) begin
        w_v_ex_nxt = 1'b0;
        w_v_id_nxt = 1'b0;
      end else if (w_loaduse) begin
        // ID instruction stays put; a bubble enters EX.
        w_v_ex_nxt = 1'b0;
        w_v_id_nxt = r_v_id;
      end else begin
        w_v_ex_nxt = r_v_id;
        w_v_id_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v_id  <= 1'b0;
      r_v_ex  <= 1'b0;
      r_v_mem <= 1'b0;
      r_v_wb  <= 1'b0;
    end else begin
      r_v_id  <= w_v_id_nxt;
      r_v_ex  <= w_v_ex_nxt;
      r_v_mem <= w_v_mem_nxt;
      r_v_wb  <= w_v_wb_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding selects
  // ---------------------------------------------------------------------------
  fwd_sel u_fwd_a (
    .i_rs           (id_rs1),
    .i_use          (id_use_rs1),
    .i_v_ex         (r_v_ex),
    .i_ex_rd        (ex_rd),
    .i_ex_regwrite  (ex_regwrite),
    .i_ex_is_load   (ex_is_load),
    .i_v_mem        (r_v_mem),
    .i_mem_rd       (mem_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_v_wb         (r_v_wb),
    .i_wb_rd        (wb_rd),
    .i_wb_regwrite  (wb_regwrite),
    .o_sel          (fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_rs           (id_rs2),
    .i_use          (id_use_rs2),
    .i_v_ex         (r_v_ex),
    .i_ex_rd        (ex_rd),
    .i_ex_regwrite  (ex_regwrite),
    .i_ex_is_load   (ex_is_load),
    .i_v_mem        (r_v_mem),
    .i_mem_rd       (mem_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_v_wb         (r_v_wb),
    .i_wb_rd        (wb_rd),
    .i_wb_regwrite  (wb_regwrite),
    .o_sel          (fwd_b)
  );

  // ---------------------------------------------------------------------------
  // Optional saturating event counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_freeze_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_freeze_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_loaduse && !w_hold && !w_redirect && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_hold && (r_freeze_cnt != '1))
        r_freeze_cnt <= r_freeze_cnt + 1'b1;
      if (w_redirect && !w_hold && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign freeze_cnt = r_freeze_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

  assign mem_err       = r_mem_err;
  assign stage_valid   = {r_v_wb, r_v_mem, r_v_ex, r_v_id};
  assign dbg_mem_state = r_state;

endmodule
